imem_port_arbiter: RTL and testbench

//  Shares one single-ported, synchronous-read instruction memory between two requesters:
//   - the core fetch port (read-only);
//   - a program-loader port (read/write), used to download and verify code.

---
 rtl/imem_arb_pkg.sv | 28 ++
 rtl/imem_addr_check.sv | 26 ++
 rtl/imem_port_arbiter.sv | 174 +++++++++++++++++
 tb/tb_imem_port_arbiter.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : imem_arb_pkg
//  Brief    : Shared types and address-legality helper for the imem arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
package imem_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_FETCH = 2'd1,
        OWN_LOAD  = 2'd2
    } owner_e;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

    // Word-aligned and inside the memory; callers zero-extend their address.
    function automatic logic addr_legal(input logic [63:0] addr, input int unsigned depth);
        logic [63:0] w_word;
        w_word = addr >> 2;
        return (addr[1:0] == 2'b00) && (w_word < 64'(depth));
    endfunction

endpackage
`default_nettype wire

// File: rtl/imem_addr_check.sv
`default_nettype none
// ============================================================================
//  Module   : imem_addr_check
//  Brief    : Byte-address alignment/range check and word-index extraction.
//  Revision : 1.0 - initial release
// ============================================================================
module imem_addr_check
    import imem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 256,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic [ADDR_W-1:0] addr,
    output logic              legal,
    output logic [AW-1:0]     word_idx
);

    always_comb begin
        legal = addr_legal(64'(addr), DEPTH);
    end

    assign word_idx = addr[AW+1:2];

endmodule
`default_nettype wire

// File: rtl/imem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : imem_port_arbiter
//  Brief    : Shares a single-ported sync-read imem between core fetch and a
//             program loader. Optional round-robin: define IMEM_ARB_RR_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module imem_port_arbiter
    import imem_arb_pkg::*;
#(
    parameter  int width       = 32,
    parameter  int Address_Bus = 32,
    parameter  int DEPTH       = 256,
    localparam int AW          = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   f_req,
    input  logic [Address_Bus-1:0] f_addr,
    output logic                   f_gnt,
    output logic                   f_rvalid,
    output logic [width-1:0]       f_rdata,
    output logic                   f_err,
    input  logic                   l_req,
    input  logic                   l_we,
    input  logic                   l_lock,
    input  logic [Address_Bus-1:0] l_addr,
    input  logic [width-1:0]       l_wdata,
    output logic                   l_gnt,
    output logic                   l_rvalid,
    output logic [width-1:0]       l_rdata,
    output logic                   l_err,
    output logic                   m_en,
    output logic                   m_we,
    output logic [AW-1:0]          m_addr,
    output logic [width-1:0]       m_wdata,
    input  logic [width-1:0]       m_rdata
);

    state_e          r_state;
    state_e          w_state_nxt;
    owner_e          r_owner;
    owner_e          w_owner_nxt;
    logic            r_err;
    logic            r_wr;
    logic            w_f_legal;
    logic            w_l_legal;
    logic [AW-1:0]   w_f_idx;
    logic [AW-1:0]   w_l_idx;
    logic            w_f_gnt;
    logic            w_l_gnt;
    logic            w_contested;
    logic            w_rr_load;

    imem_addr_check #(.ADDR_W(Address_Bus), .DEPTH(DEPTH), .AW(AW)) u_f_check (
        .addr     (f_addr),
        .legal    (w_f_legal),
        .word_idx (w_f_idx)
    );

    imem_addr_check #(.ADDR_W(Address_Bus), .DEPTH(DEPTH), .AW(AW)) u_l_check (
        .addr     (l_addr),
        .legal    (w_l_legal),
        .word_idx (w_l_idx)
    );

    assign w_contested = rst_n && (r_state == ST_IDLE) && f_req && l_req;

`ifdef IMEM_ARB_RR_EN
    // 0: fetch wins the next contested cycle, 1: loader wins it.
    logic r_rr_load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_load <= 1'b0;
        end else if (w_contested) begin
            r_rr_load <= ~r_rr_load;
        end
    end

    assign w_rr_load = r_rr_load;
`else
    assign w_rr_load = 1'b1;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: the cycle that drops l_lock is still arbitrated as locked.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (w_l_gnt && l_lock) w_state_nxt = ST_LOCKED;
            ST_LOCKED: if (!l_lock)           w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // Grant outputs
    always_comb begin
        w_f_gnt = 1'b0;
        w_l_gnt = 1'b0;
        if (rst_n) begin
            case (r_state)
                ST_LOCKED: w_l_gnt = l_req;
                default: begin
                    if (w_contested) begin
                        w_l_gnt = w_rr_load;
                        w_f_gnt = ~w_rr_load;
                    end else begin
                        w_l_gnt = l_req;
                        w_f_gnt = f_req;
                    end
                end
            endcase
        end
    end

    assign f_gnt = w_f_gnt;
    assign l_gnt = w_l_gnt;

    // Illegal requests are granted but never reach the memory.
    always_comb begin
        m_en    = 1'b0;
        m_we    = 1'b0;
        m_addr  = '0;
        m_wdata = '0;
        if (w_l_gnt && w_l_legal) begin
            m_en    = 1'b1;
            m_we    = l_we;
            m_addr  = w_l_idx;
            m_wdata = l_we ? l_wdata : '0;
        end else if (w_f_gnt && w_f_legal) begin
            m_en    = 1'b1;
            m_addr  = w_f_idx;
        end
    end

    always_comb begin
        w_owner_nxt = OWN_NONE;
        if (w_l_gnt) begin
            w_owner_nxt = OWN_LOAD;
        end else if (w_f_gnt) begin
            w_owner_nxt = OWN_FETCH;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner <= OWN_NONE;
            r_err   <= 1'b0;
            r_wr    <= 1'b0;
        end else begin
            r_owner <= w_owner_nxt;
            r_err   <= (w_l_gnt && !w_l_legal) || (w_f_gnt && !w_f_legal);
            r_wr    <= w_l_gnt && l_we;
        end
    end

    assign f_rvalid = (r_owner == OWN_FETCH);
    assign l_rvalid = (r_owner == OWN_LOAD);
    assign f_err    = f_rvalid && r_err;
    assign l_err    = l_rvalid && r_err;
    assign f_rdata  = (f_rvalid && !r_err) ? m_rdata : '0;
    assign l_rdata  = (l_rvalid && !r_err && !r_wr) ? m_rdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_imem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_imem_port_arbiter
//  Brief    : Directed self-checking bench with a cycle-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_imem_port_arbiter;

    localparam int c_DEPTH = 256;
    localparam int c_AW    = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              f_req = 1'b0;
    logic [31:0]       f_addr = '0;
    logic              f_gnt, f_rvalid, f_err;
    logic [31:0]       f_rdata;
    logic              l_req = 1'b0, l_we = 1'b0, l_lock = 1'b0;
    logic [31:0]       l_addr = '0, l_wdata = '0;
    logic              l_gnt, l_rvalid, l_err;
    logic [31:0]       l_rdata;
    logic              m_en, m_we;
    logic [c_AW-1:0]   m_addr;
    logic [31:0]       m_wdata, m_rdata;
    logic [31:0]       sram_q;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    imem_port_arbiter #(.width(32), .Address_Bus(32), .DEPTH(c_DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid),
        .f_rdata(f_rdata), .f_err(f_err),
        .l_req(l_req), .l_we(l_we), .l_lock(l_lock), .l_addr(l_addr), .l_wdata(l_wdata),
        .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata), .l_err(l_err),
        .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
    );

    // Synchronous-read memory attached to the arbiter.
    assign m_rdata = sram_q;
    initial begin : sram_proc
        logic [31:0] sram [c_DEPTH];
        for (int i = 0; i < c_DEPTH; i++) sram[i] = 32'h1000_0000 + 32'(i);
        sram_q = '0;
        forever begin
            @(posedge clk);
            if (m_en) begin
                if (m_we) sram[m_addr] <= m_wdata;
                else      sram_q <= sram[m_addr];
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic legal(input logic [31:0] a);
        return (a % 4 == 0) && (a / 4 < 32'(c_DEPTH));
    endfunction

    // Reference model: evaluated mid-cycle, predicts grants/memory drive now and responses next cycle.
    initial begin : model
        logic [31:0]     ref_mem [c_DEPTH];
        logic            p_valid, p_load, p_err;
        logic [31:0]     p_data;
        logic            locked, rr_load;
        logic            fg, lg, fl, ll, en, we;
        logic [c_AW-1:0] fi, li, ea;
        logic [31:0]     ewd;
        for (int i = 0; i < c_DEPTH; i++) ref_mem[i] = 32'h1000_0000 + 32'(i);
        p_valid = 0; p_load = 0; p_err = 0; p_data = 0; locked = 0; rr_load = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                check("rst f_gnt", 32'(f_gnt), 0);     check("rst l_gnt", 32'(l_gnt), 0);
                check("rst f_rvalid", 32'(f_rvalid), 0); check("rst l_rvalid", 32'(l_rvalid), 0);
                check("rst f_err", 32'(f_err), 0);     check("rst l_err", 32'(l_err), 0);
                check("rst f_rdata", f_rdata, 0);      check("rst l_rdata", l_rdata, 0);
                check("rst m_en", 32'(m_en), 0);       check("rst m_we", 32'(m_we), 0);
                check("rst m_addr", 32'(m_addr), 0);   check("rst m_wdata", m_wdata, 0);
                p_valid = 0; locked = 0; rr_load = 0;
            end else begin
                check("f_rvalid", 32'(f_rvalid), 32'(p_valid && !p_load));
                check("l_rvalid", 32'(l_rvalid), 32'(p_valid && p_load));
                check("f_err", 32'(f_err), 32'(p_valid && !p_load && p_err));
                check("l_err", 32'(l_err), 32'(p_valid && p_load && p_err));
                check("f_rdata", f_rdata, (p_valid && !p_load) ? p_data : 32'h0);
                check("l_rdata", l_rdata, (p_valid && p_load) ? p_data : 32'h0);

                fl = legal(f_addr);
                ll = legal(l_addr);
                fi = c_AW'(f_addr / 4);
                li = c_AW'(l_addr / 4);
                if (locked) begin
                    lg = l_req; fg = 1'b0;
                end else if (l_req && f_req) begin
`ifdef IMEM_ARB_RR_EN
                    lg = rr_load; fg = !rr_load; rr_load = !rr_load;
`else
                    lg = 1'b1; fg = 1'b0;
`endif
                end else begin
                    lg = l_req; fg = f_req;
                end
                en  = (lg && ll) || (fg && fl);
                we  = lg && ll && l_we;
                ea  = en ? (lg ? li : fi) : '0;
                ewd = we ? l_wdata : 32'h0;
                check("f_gnt", 32'(f_gnt), 32'(fg));
                check("l_gnt", 32'(l_gnt), 32'(lg));
                check("m_en", 32'(m_en), 32'(en));
                check("m_we", 32'(m_we), 32'(we));
                check("m_addr", 32'(m_addr), 32'(ea));
                check("m_wdata", m_wdata, ewd);

                p_valid = fg || lg;
                p_load  = lg;
                p_err   = lg ? !ll : (fg ? !fl : 1'b0);
                p_data  = 32'h0;
                if (p_valid && !p_err && !(lg && l_we)) p_data = ref_mem[lg ? li : fi];
                if (we) ref_mem[li] = l_wdata;
                locked = locked ? l_lock : (lg && l_lock);
            end
        end
    end

    task automatic drive(input logic fr, input logic [31:0] fa, input logic lr, input logic lw,
                         input logic lk, input logic [31:0] la, input logic [31:0] ld);
        f_req = fr; f_addr = fa; l_req = lr; l_we = lw; l_lock = lk; l_addr = la; l_wdata = ld;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic to_mid();
        @(negedge clk); #1;
    endtask

    task automatic to_next();
        @(posedge clk); #1;
    endtask

    initial begin : stim
        idle();
        to_mid();
        check("init f_rvalid", 32'(f_rvalid), 0);
        check("init m_en", 32'(m_en), 0);
        repeat (2) to_next();
        rst_n = 1'b1;

        // Fetch alone, three consecutive words
        drive(1, 32'h0, 0, 0, 0, 0, 0); to_mid();
        check("t2 gnt0", 32'(f_gnt), 1); to_next();
        drive(1, 32'h4, 0, 0, 0, 0, 0); to_mid();
        check("t2 gnt1", 32'(f_gnt), 1); check("t2 rv0", 32'(f_rvalid), 1);
        check("t2 rd0", f_rdata, 32'h1000_0000); to_next();
        drive(1, 32'h8, 0, 0, 0, 0, 0); to_mid();
        check("t2 rd1", f_rdata, 32'h1000_0001); to_next();
        idle(); to_mid();
        check("t2 rd2", f_rdata, 32'h1000_0002); check("t2 err", 32'(f_err), 0); to_next();

        // Loader write, then fetch reads it back on the very next cycle
        drive(0, 0, 1, 1, 0, 32'h10, 32'hDEAD_BEEF); to_mid();
        check("t3 l_gnt", 32'(l_gnt), 1); check("t3 m_we", 32'(m_we), 1);
        check("t3 m_addr", 32'(m_addr), 4); to_next();
        drive(1, 32'h10, 0, 0, 0, 0, 0); to_mid();
        check("t3 ack", 32'(l_rvalid), 1); check("t3 ack data", l_rdata, 0); to_next();
        idle(); to_mid();
        check("t3 readback", f_rdata, 32'hDEAD_BEEF); to_next();

        // Contention
        for (int i = 0; i < 4; i++) begin
            drive(1, 32'h24, 1, 0, 0, 32'h20, 0); to_mid();
`ifdef IMEM_ARB_RR_EN
            check("t4 f_gnt", 32'(f_gnt), 32'(i % 2 == 0));
            check("t4 l_gnt", 32'(l_gnt), 32'(i % 2 == 1));
`else
            check("t4 f_gnt", 32'(f_gnt), 0);
            check("t4 l_gnt", 32'(l_gnt), 1);
`endif
            to_next();
        end
        idle(); to_mid(); to_next();

        // Locked burst with fetch waiting
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'h0, 1, 1, 1, 32'h30 + 32'(4 * i), 32'hC0DE_0000 + 32'(i)); to_mid();
`ifndef IMEM_ARB_RR_EN
            check("t5 f_gnt locked", 32'(f_gnt), 0);
            check("t5 l_gnt locked", 32'(l_gnt), 1);
`endif
            to_next();
        end
        drive(1, 32'h0, 0, 0, 0, 0, 0); to_mid();
        check("t5 f_gnt unlock cycle", 32'(f_gnt), 0); to_next();
        drive(1, 32'h0, 0, 0, 0, 0, 0); to_mid();
        check("t5 f_gnt after unlock", 32'(f_gnt), 1); to_next();
        drive(0, 0, 1, 0, 0, 32'h34, 0); to_mid(); to_next();
        idle(); to_mid();
        check("t5 readback", l_rdata, 32'hC0DE_0001); to_next();

        // Illegal addresses
        drive(1, 32'h6, 0, 0, 0, 0, 0); to_mid();
        check("t6 f_gnt", 32'(f_gnt), 1); check("t6 m_en", 32'(m_en), 0); to_next();
        idle(); to_mid();
        check("t6 f_err", 32'(f_err), 1); check("t6 f_rdata", f_rdata, 0); to_next();
        drive(0, 0, 1, 1, 0, 32'h400, 32'h1234_5678); to_mid();
        check("t6 l_gnt", 32'(l_gnt), 1); check("t6 m_we", 32'(m_we), 0); to_next();
        idle(); to_mid();
        check("t6 l_err", 32'(l_err), 1); to_next();
        drive(0, 0, 1, 1, 0, 32'h11, 32'h5555_5555); to_mid(); to_next();
        drive(1, 32'h0, 0, 0, 0, 0, 0); to_mid(); to_next();
        drive(1, 32'h10, 0, 0, 0, 0, 0); to_mid();
        check("t6 word0 intact", f_rdata, 32'h1000_0000); to_next();
        idle(); to_mid();
        check("t6 word4 intact", f_rdata, 32'hDEAD_BEEF); to_next();

        // Reset while a read is in flight
        drive(1, 32'h4, 0, 0, 0, 0, 0); to_mid(); to_next();
        rst_n = 1'b0;
        idle(); to_mid();
        check("t1 rvalid in reset", 32'(f_rvalid), 0);
        check("t1 rdata in reset", f_rdata, 0);
        to_next(); to_next();
        rst_n = 1'b1;
        to_mid();
        check("t1 no rvalid after", 32'(f_rvalid), 0); to_next();
        drive(1, 32'h8, 0, 0, 0, 0, 0); to_mid(); to_next();
        idle(); to_mid();
        check("t1 read after reset", f_rdata, 32'h1000_0002); to_next();

        repeat (2) to_next();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
